// File: rtl/reg_select_pkg.sv
// Shared definitions for the register select sequencer: phase encoding,
// instruction mode codes and the bit positions of the register fields.
package reg_select_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SRC_B = 3'd1,
      ST_SRC_C = 3'd2,
      ST_SRC_A = 3'd3,
      ST_DST_A = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ALU3  = 2'b00;
   localparam mode_t MODE_BASE  = 2'b01;
   localparam mode_t MODE_STORE = 2'b10;
   localparam mode_t MODE_UNARY = 2'b11;

   // LSB of each register field inside the instruction word
   localparam int unsigned RA_LSB = 23;
   localparam int unsigned RB_LSB = 19;
   localparam int unsigned RC_LSB = 15;

   // Modes whose first operand is a base address (R0 reads as zero)
   function automatic logic is_ba_mode(input mode_t m);
      return (m == MODE_BASE) || (m == MODE_STORE);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary field to one-hot register enable, gated by an enable. With the
// enable low the output is all zero, so at most one bit is ever set.
module onehot_decoder #(
   parameter int FIELD_W  = 4,
   parameter int NUM_REGS = 16
) (
   input  logic                en_i,
   input  logic [FIELD_W-1:0]  sel_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   // Compare the select against every register index
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en_i && (sel_i == FIELD_W'(i))) begin
            onehot_o[i] = 1'b1;
         end else begin
            onehot_o[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_select_sequencer.sv
// Select-and-encode sequencer for the Mini-SRC register file. On an accepted
// start it latches Ra/Rb/Rc and the mode, then walks operand-read and
// result-write phases, driving one-hot Rout/Rin and BAout. Outputs are Moore:
// decoded only from the current phase and the latched fields.
module reg_select_sequencer
   import reg_select_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int FIELD_W  = 4
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [31:0]         ir_in,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic                hold,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic                BAout,
   output logic                busy,
   output logic                done
);

   state_e               state_q, state_d;
   logic [FIELD_W-1:0]   ra_q, ra_d;
   logic [FIELD_W-1:0]   rb_q, rb_d;
   logic [FIELD_W-1:0]   rc_q, rc_d;
   mode_t                mode_q, mode_d;

   logic                 rd_en_s;
   logic [FIELD_W-1:0]   rd_sel_s;
   logic                 wr_en_s;
   logic                 accept_s;

   // Instruction bits outside the three register fields are not used here
   logic                 unused_ir_s;
   assign unused_ir_s = ^{ir_in[31:RA_LSB+FIELD_W], ir_in[RC_LSB-1:0]};

   assign accept_s = (state_q == ST_IDLE) && start;

   // Phase register and field/mode latches; clr forces IDLE immediately
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         mode_q  <= MODE_ALU3;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         mode_q  <= mode_d;
      end
   end

   // Next phase and field capture; hold repeats any operand/result phase
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      mode_d  = mode_q;

      if (accept_s) begin
         ra_d   = ir_in[RA_LSB +: FIELD_W];
         rb_d   = ir_in[RB_LSB +: FIELD_W];
         rc_d   = ir_in[RC_LSB +: FIELD_W];
         mode_d = mode;
      end else begin
         ra_d   = ra_q;
         rb_d   = rb_q;
         rc_d   = rc_q;
         mode_d = mode_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SRC_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SRC_B: begin
            if (hold) begin
               state_d = ST_SRC_B;
            end else begin
               case (mode_q)
                  MODE_ALU3:  state_d = ST_SRC_C;
                  MODE_BASE:  state_d = ST_DST_A;
                  MODE_STORE: state_d = ST_SRC_A;
                  MODE_UNARY: state_d = ST_DST_A;
                  default:    state_d = ST_IDLE;
               endcase
            end
         end
         ST_SRC_C: begin
            if (hold) begin
               state_d = ST_SRC_C;
            end else begin
               state_d = ST_DST_A;
            end
         end
         ST_SRC_A: begin
            if (hold) begin
               state_d = ST_SRC_A;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DST_A: begin
            if (hold) begin
               state_d = ST_DST_A;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore decode of the bus selects and status flags from the phase
   always_comb begin
      rd_en_s  = 1'b0;
      rd_sel_s = '0;
      wr_en_s  = 1'b0;
      BAout    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_SRC_B: begin
            rd_en_s  = 1'b1;
            rd_sel_s = rb_q;
            BAout    = is_ba_mode(mode_q);
         end
         ST_SRC_C: begin
            rd_en_s  = 1'b1;
            rd_sel_s = rc_q;
         end
         ST_SRC_A: begin
            rd_en_s  = 1'b1;
            rd_sel_s = ra_q;
         end
         ST_DST_A: begin
            wr_en_s = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   onehot_decoder #(
      .FIELD_W  (FIELD_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd_dec (
      .en_i     (rd_en_s),
      .sel_i    (rd_sel_s),
      .onehot_o (Rout)
   );

   onehot_decoder #(
      .FIELD_W  (FIELD_W),
      .NUM_REGS (NUM_REGS)
   ) u_wr_dec (
      .en_i     (wr_en_s),
      .sel_i    (ra_q),
      .onehot_o (Rin)
   );

endmodule
